bw_io_jp_bsr_tap_ctl: RTL



---
 rtl/bw_io_jp_bsr_tap_ctl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bw_io_jp_bsr_tap_ctl.sv
// -----------------------------------------------------------------------------
// bw_io_jp_bsr_tap_ctl
//   JTAG TAP controller for the pad boundary-scan register (BSR) chain.
//   It owns the 16-state TAP FSM, the instruction register, the bypass and
//   IDCODE data registers, and the TDO mux. It also generates the shift,
//   capture and update controls plus the output-mode and hi-Z selects for
//   the per-pad scan cells.
//
// Ports
//   clk        TCK-domain clock; every state change happens on its rising edge
//   rst_l      synchronous active-low reset
//   tms, tdi   JTAG mode select / serial data in
//   tdo        registered serial data out
//   tdo_en     high in the cycle after each SHIFT_IR / SHIFT_DR cycle
//   bsr_si     serial input to the BSR chain head (tdi pass-through)
//   bsr_so     serial output from the BSR chain tail
//   shift_dr   BSR shift select
//   clock_dr   BSR capture/shift clock enable
//   update_dr  BSR update strobe
//   mode_ctl   1 = pads driven from the BSR update stage
//   bsr_hiz_l  0 = force all BSR-controlled pads hi-Z
//   ir_q       active (updated) instruction
// -----------------------------------------------------------------------------
module bw_io_jp_bsr_tap_ctl #(
   parameter int unsigned IR_W       = 4,
   parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic            tms,
   input  logic            tdi,
   output logic            tdo,
   output logic            tdo_en,
   output logic            bsr_si,
   input  logic            bsr_so,
   output logic            shift_dr,
   output logic            clock_dr,
   output logic            update_dr,
   output logic            mode_ctl,
   output logic            bsr_hiz_l,
   output logic [IR_W-1:0] ir_q
);

   typedef enum logic [3:0] {
      TLR, RTI,
      SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_state_e;

   localparam logic [IR_W-1:0] OP_EXTEST  = IR_W'(4'b0000);
   localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(4'b0001);
   localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(4'b0010);
   localparam logic [IR_W-1:0] OP_HIGHZ   = IR_W'(4'b0011);
   localparam logic [IR_W-1:0] OP_CLAMP   = IR_W'(4'b0100);
   localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

   tap_state_e      state_q, state_d;
   logic [IR_W-1:0] ir_sr_q;
   logic [IR_W-1:0] ir_d;
   logic [31:0]     id_sr_q;
   logic            byp_q;
   logic            tdo_q, tdo_en_q;
   logic            shift_dr_q, clock_dr_q, update_dr_q;
   logic            mode_ctl_q, hiz_l_q;
   logic            sel_bsr, sel_id;

   // Data-register select follows the active instruction; every code that
   // is neither a BSR nor the IDCODE instruction falls back to bypass.
   assign sel_bsr = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);
   assign sel_id  = (ir_q == OP_IDCODE);

   // IEEE 1149.1 state transitions.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         TLR:    state_d = tms ? TLR    : RTI;
         RTI:    state_d = tms ? SEL_DR : RTI;
         SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
         CAP_DR: state_d = tms ? EX1_DR : SH_DR;
         SH_DR:  state_d = tms ? EX1_DR : SH_DR;
         EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
         PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
         EX2_DR: state_d = tms ? UPD_DR : SH_DR;
         UPD_DR: state_d = tms ? SEL_DR : RTI;
         SEL_IR: state_d = tms ? TLR    : CAP_IR;
         CAP_IR: state_d = tms ? EX1_IR : SH_IR;
         SH_IR:  state_d = tms ? EX1_IR : SH_IR;
         EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
         PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
         EX2_IR: state_d = tms ? UPD_IR : SH_IR;
         UPD_IR: state_d = tms ? SEL_DR : RTI;
      endcase
   end

   // Next active instruction: reloaded to IDCODE whenever the FSM enters
   // TEST_LOGIC_RESET, loaded from the shift register on leaving UPDATE_IR.
   always_comb begin
      ir_d = ir_q;
      if (state_d == TLR) begin
         ir_d = OP_IDCODE;
      end else if (state_q == UPD_IR) begin
         ir_d = ir_sr_q;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of its neighbours.
      if (!rst_l) begin
         state_q     <= TLR;
         ir_q        <= OP_IDCODE;
         ir_sr_q     <= IR_CAPTURE;
         id_sr_q     <= IDCODE_VAL;
         byp_q       <= 1'b0;
         tdo_q       <= 1'b0;
         tdo_en_q    <= 1'b0;
         shift_dr_q  <= 1'b0;
         clock_dr_q  <= 1'b0;
         update_dr_q <= 1'b0;
         mode_ctl_q  <= 1'b0;
         hiz_l_q     <= 1'b1;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;

         // Mode selects track the instruction, so they move only when ir_q does.
         mode_ctl_q <= (ir_d == OP_EXTEST) || (ir_d == OP_HIGHZ) || (ir_d == OP_CLAMP);
         hiz_l_q    <= (ir_d != OP_HIGHZ);

         // Decoded from the next state so each strobe is high exactly while
         // the FSM sits in the named state.
         clock_dr_q  <= sel_bsr && ((state_d == CAP_DR) || (state_d == SH_DR));
         shift_dr_q  <= sel_bsr && (state_d == SH_DR);
         update_dr_q <= sel_bsr && (state_d == UPD_DR);

         tdo_en_q <= 1'b0;
         case (state_q)
            CAP_IR: ir_sr_q <= IR_CAPTURE;
            SH_IR: begin
               tdo_q    <= ir_sr_q[0];
               tdo_en_q <= 1'b1;
               ir_sr_q  <= {tdi, ir_sr_q[IR_W-1:1]};
            end
            CAP_DR: begin
               if (sel_id) begin
                  id_sr_q <= IDCODE_VAL;
               end else if (!sel_bsr) begin
                  byp_q <= 1'b0;
               end
            end
            SH_DR: begin
               tdo_en_q <= 1'b1;
               if (sel_bsr) begin
                  tdo_q <= bsr_so;
               end else if (sel_id) begin
                  tdo_q   <= id_sr_q[0];
                  id_sr_q <= {tdi, id_sr_q[31:1]};
               end else begin
                  tdo_q <= byp_q;
                  byp_q <= tdi;
               end
            end
            // EXIT/PAUSE states leave every shift register untouched.
            default: ;
         endcase
      end
   end

   assign tdo       = tdo_q;
   assign tdo_en    = tdo_en_q;
   assign bsr_si    = tdi;
   assign shift_dr  = shift_dr_q;
   assign clock_dr  = clock_dr_q;
   assign update_dr = update_dr_q;
   assign mode_ctl  = mode_ctl_q;
   assign bsr_hiz_l = hiz_l_q;

endmodule
